// File: rtl/mem_port_if.sv
// Request/response bundle between the CPU load/store/fetch logic and the
// memory port controller.
interface mem_port_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [LEN_W-1:0]  req_len;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              wr_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_len,
      input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_len,
      output req_ready, rsp_valid, rsp_data, rsp_last, wr_done
   );
endinterface

// File: rtl/mem_port_ctrl.sv
// Initiator for the 512 x 16 single-port data memory: single-beat writes and
// 1..8-beat incrementing read bursts returned as a response stream.
//
// state | meaning
// IDLE  | ready for a request, mem pins hold last values
// WRITE | mem_we asserted for one cycle, wr_done pulses
// READ  | one address issued per cycle, burst counter counts down to 0
// DRAIN | waiting for the two-cycle read pipeline to empty
module mem_port_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_if.slave         bus,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state, next_state;
   logic              accept;
   logic [LEN_W-1:0]  cnt;
   logic              req_ready_q;
   logic              wr_done_q;
   logic              d_v, d_last;
   logic              rsp_valid_q, rsp_last_q;
   logic [DATA_W-1:0] rsp_data_q;

   assign bus.req_ready = req_ready_q;
   assign bus.wr_done   = wr_done_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_last  = rsp_last_q;
   assign bus.rsp_data  = rsp_data_q;

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               accept     = 1'b1;
               next_state = bus.req_we ? WRITE : READ;
            end
         end
         WRITE:   next_state = IDLE;
         READ:    if (cnt == '0) next_state = DRAIN;
         DRAIN:   if (rsp_last_q) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         wr_done_q   <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         d_v         <= 1'b0;
         d_last      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state       <= next_state;
         req_ready_q <= (next_state == IDLE);
         mem_we      <= (next_state == WRITE);
         wr_done_q   <= (next_state == WRITE);

         if (accept) begin
            mem_address <= bus.req_addr;
            cnt         <= bus.req_we ? '0 : bus.req_len;
            if (bus.req_we) mem_data_in <= bus.req_wdata;
         end else if (state == READ && cnt != '0) begin
            mem_address <= mem_address + 1'b1;
            cnt         <= cnt - 1'b1;
         end

         // address issued in cycle k -> data_out at k+1 -> response at k+2
         d_v         <= (state == READ);
         d_last      <= (state == READ) && (cnt == '0);
         rsp_valid_q <= d_v;
         rsp_last_q  <= d_last;
         if (d_v) rsp_data_q <= mem_data_out;
      end
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: behavioural memory, scoreboard of expected beats
// and writes, and per-scenario timing checks.
module tb_mem_port_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_we;
   logic [8:0]  mem_address;
   logic [15:0] mem_data_in;
   logic [15:0] mem_data_out;

   mem_port_if #(.ADDR_W(9), .DATA_W(16), .LEN_W(3)) bus ();

   mem_port_ctrl #(.ADDR_W(9), .DATA_W(16), .LEN_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .mem_we       (mem_we),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem     [512];
   logic [15:0] ref_mem [512];

   always @(posedge clk) begin
      if (mem_we) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem[mem_address];
   end

   int checks = 0;
   int errors = 0;
   int beat_cnt = 0;
   bit in_burst = 0;
   logic [16:0] eq[$];
   logic [24:0] wq[$];

   // scoreboard monitor: response beats and memory writes
   always @(negedge clk) begin
      logic [16:0] e;
      logic [24:0] w;
      if (rst) begin
         in_burst = 0;
      end else begin
         if (bus.rsp_valid) begin
            checks++;
            if (eq.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: got data=%h last=%0b, want no beat", bus.rsp_data, bus.rsp_last);
            end else begin
               e = eq.pop_front();
               if ({bus.rsp_last, bus.rsp_data} !== e) begin
                  errors++;
                  $display("FAIL rsp_beat: got last=%0b data=%h, want last=%0b data=%h",
                           bus.rsp_last, bus.rsp_data, e[16], e[15:0]);
               end
            end
            beat_cnt++;
            in_burst = !bus.rsp_last;
         end else if (in_burst) begin
            checks++;
            errors++;
            $display("FAIL rsp_gap: got rsp_valid=0 mid-burst, want 1");
            in_burst = 0;
         end
         if (mem_we) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL mem_we_unexpected: got write addr=%h data=%h, want none", mem_address, mem_data_in);
            end else begin
               w = wq.pop_front();
               if ({mem_address, mem_data_in, bus.wr_done} !== {w, 1'b1}) begin
                  errors++;
                  $display("FAIL mem_write: got addr=%h data=%h wr_done=%0b, want addr=%h data=%h wr_done=1",
                           mem_address, mem_data_in, bus.wr_done, w[24:16], w[15:0]);
               end
            end
         end
      end
   end

   task automatic send(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                       input logic [2:0] len, input bit hold);
      int n;
      logic [8:0] a;
      if (!bus.req_valid) @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_len   = len;
      if (we) begin
         wq.push_back({addr, wdata});
         ref_mem[addr] = wdata;
      end else begin
         for (int i = 0; i <= int'(len); i++) begin
            a = addr + 9'(i);
            eq.push_back({(i == int'(len)), ref_mem[a]});
         end
      end
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, want 1", n);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.req_ready && eq.size() == 0) && n < 100);
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL idle_timeout: got req_ready=%0b pending=%0d, want 1 and 0", bus.req_ready, eq.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus.req_ready, mem_we, bus.wr_done, bus.rsp_valid, bus.rsp_last, mem_address} !== {5'b10000, 9'h000}) begin
         errors++;
         $display("FAIL reset_values: got ready=%0b we=%0b wr_done=%0b rsp_valid=%0b last=%0b addr=%h, want 1 0 0 0 0 000",
                  bus.req_ready, mem_we, bus.wr_done, bus.rsp_valid, bus.rsp_last, mem_address);
      end
   endtask

   task automatic test_write();
      send(1'b1, 9'h000, 16'h0003, 3'd0, 1'b0);
      @(negedge clk);
      checks++;
      if ({mem_we, bus.wr_done, bus.req_ready} !== 3'b110) begin
         errors++;
         $display("FAIL write_t1: got we=%0b wr_done=%0b ready=%0b, want 1 1 0", mem_we, bus.wr_done, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({mem_we, bus.wr_done, bus.req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL write_t2: got we=%0b wr_done=%0b ready=%0b, want 0 0 1", mem_we, bus.wr_done, bus.req_ready);
      end
   endtask

   task automatic test_read_single();
      send(1'b0, 9'h000, 16'h0000, 3'd0, 1'b0);
      @(negedge clk);
      checks++;
      if ({mem_we, bus.req_ready, mem_address} !== {2'b00, 9'h000}) begin
         errors++;
         $display("FAIL read_t1: got we=%0b ready=%0b addr=%h, want 0 0 000", mem_we, bus.req_ready, mem_address);
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_t2: got rsp_valid=%0b, want 0", bus.rsp_valid);
      end
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.req_ready} !== {2'b11, 16'h0003, 1'b0}) begin
         errors++;
         $display("FAIL read_t3: got valid=%0b last=%0b data=%h ready=%0b, want 1 1 0003 0",
                  bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
         errors++;
         $display("FAIL read_t4: got ready=%0b rsp_valid=%0b, want 1 0", bus.req_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_wrap();
      logic [8:0] exp_a [3];
      exp_a[0] = 9'd510;
      exp_a[1] = 9'd511;
      exp_a[2] = 9'd0;
      send(1'b1, 9'd510, 16'h1A1A, 3'd0, 1'b0);
      send(1'b1, 9'd511, 16'h2B2B, 3'd0, 1'b0);
      send(1'b1, 9'd0,   16'h3C3C, 3'd0, 1'b0);
      send(1'b0, 9'd510, 16'h0000, 3'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_we, mem_address} !== {1'b0, exp_a[i]}) begin
            errors++;
            $display("FAIL wrap_addr%0d: got we=%0b addr=%0d, want 0 %0d", i, mem_we, mem_address, exp_a[i]);
         end
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      int bc0;
      bc0 = beat_cnt;
      send(1'b0, 9'h100, 16'h0000, 3'd7, 1'b1);
      send(1'b1, 9'h103, 16'hBEEF, 3'd0, 1'b0);
      checks++;
      if (beat_cnt - bc0 != 8) begin
         errors++;
         $display("FAIL b2b_order: got %0d beats before write accept, want 8", beat_cnt - bc0);
      end
      wait_idle();
      send(1'b0, 9'h103, 16'h0000, 3'd0, 1'b0);
      wait_idle();
   endtask

   task automatic test_reset_mid_read();
      send(1'b0, 9'h040, 16'h0000, 3'd7, 1'b0);
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, mem_we, bus.req_ready} !== 3'b001) begin
         errors++;
         $display("FAIL rst_mid: got rsp_valid=%0b we=%0b ready=%0b, want 0 0 1", bus.rsp_valid, mem_we, bus.req_ready);
      end
      eq.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop%0d: got rsp_valid=%0b, want 0", i, bus.rsp_valid);
         end
      end
      send(1'b0, 9'h041, 16'h0000, 3'd1, 1'b0);
      wait_idle();
   endtask

   task automatic test_ignored_req();
      int beats;
      send(1'b1, 9'h055, 16'h5555, 3'd0, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 9'h066;
      bus.req_wdata = 16'h6666;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL ign_write%0d: got mem_we=%0b, want 0", i, mem_we);
         end
      end
      send(1'b0, 9'h055, 16'h0000, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 9'h010;
      bus.req_len   = 3'd3;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      beats = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) beats++;
      end
      checks++;
      if (beats != 1) begin
         errors++;
         $display("FAIL ign_drain: got %0d beats, want 1", beats);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i]     = 16'(i * 37) ^ 16'h5A5A;
         ref_mem[i] = 16'(i * 37) ^ 16'h5A5A;
      end
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_len   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      test_reset();
      test_write();
      test_read_single();
      test_wrap();
      test_back_to_back();
      test_reset_mid_read();
      test_ignored_req();

      checks++;
      if (eq.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL leftover: got pending beats=%0d writes=%0d, want 0 0", eq.size(), wq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
